// File: rtl/button_debouncer.sv
// button_debouncer: synchronizes and debounces a push-button, producing level, press/release/hold pulses and a press counter
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 100_000_000,
  parameter int CNT_W           = 27
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_btn_raw,
  input  logic       i_count_clr,
  output logic       o_btn_level,
  output logic       o_press_pulse,
  output logic       o_release_pulse,
  output logic       o_btn_held,
  output logic       o_hold_pulse,
  output logic [7:0] o_press_count
);
  typedef enum logic [1:0] {UP, WAIT_DOWN, DOWN, WAIT_UP} state_t;
  localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);
  state_t           r_state, w_state_nx;
  logic             r_sync1, r_sync2;
  logic [CNT_W-1:0] r_deb_cnt, w_deb_nx, r_hold_cnt, w_hold_nx;
  logic             w_level_nx, w_press_nx, w_rel_nx, w_held_nx, w_hold_p_nx;
  logic [7:0]       w_count_nx;
  always_comb begin
    w_state_nx  = r_state;
    w_deb_nx    = r_deb_cnt;
    w_hold_nx   = r_hold_cnt;
    w_level_nx  = o_btn_level;
    w_held_nx   = o_btn_held;
    w_press_nx  = 1'b0;
    w_rel_nx    = 1'b0;
    w_hold_p_nx = 1'b0;
    case (r_state)
      UP: if (r_sync2) begin
        w_state_nx = WAIT_DOWN;
        w_deb_nx   = '0;
      end
      WAIT_DOWN: if (!r_sync2) w_state_nx = UP;
      else if (r_deb_cnt == DEB_MAX) begin
        w_state_nx = DOWN;
        w_level_nx = 1'b1;
        w_press_nx = 1'b1;
        w_hold_nx  = '0;
      end else w_deb_nx = r_deb_cnt + 1'b1;
      DOWN: if (!r_sync2) begin
        w_state_nx = WAIT_UP;
        w_deb_nx   = '0;
      end else if (!o_btn_held) begin
        w_held_nx   = r_hold_cnt == HOLD_MAX;
        w_hold_p_nx = r_hold_cnt == HOLD_MAX;
        w_hold_nx   = r_hold_cnt == HOLD_MAX ? r_hold_cnt : r_hold_cnt + 1'b1;
      end
      WAIT_UP: if (r_sync2) w_state_nx = DOWN;
      else if (r_deb_cnt == DEB_MAX) begin
        w_state_nx = UP;
        w_level_nx = 1'b0;
        w_rel_nx   = 1'b1;
        w_held_nx  = 1'b0;
      end else w_deb_nx = r_deb_cnt + 1'b1;
      default: w_state_nx = UP;
    endcase
    w_count_nx = i_count_clr ? {7'd0, w_press_nx} : o_press_count + {7'd0, w_press_nx};
  end
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state         <= UP;
      r_sync1         <= 1'b0;
      r_sync2         <= 1'b0;
      r_deb_cnt       <= '0;
      r_hold_cnt      <= '0;
      o_btn_level     <= 1'b0;
      o_press_pulse   <= 1'b0;
      o_release_pulse <= 1'b0;
      o_btn_held      <= 1'b0;
      o_hold_pulse    <= 1'b0;
      o_press_count   <= '0;
    end else begin
      r_state         <= w_state_nx;
      r_sync1         <= i_btn_raw;
      r_sync2         <= r_sync1;
      r_deb_cnt       <= w_deb_nx;
      r_hold_cnt      <= w_hold_nx;
      o_btn_level     <= w_level_nx;
      o_press_pulse   <= w_press_nx;
      o_release_pulse <= w_rel_nx;
      o_btn_held      <= w_held_nx;
      o_hold_pulse    <= w_hold_p_nx;
      o_press_count   <= w_count_nx;
    end
  end
endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: directed stimulus with a window/run-length reference model checked every cycle
module tb_button_debouncer;
  localparam int D = 4;
  localparam int H = 10;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_raw = 1'b0;
  logic count_clr = 1'b0;
  logic btn_level, press_pulse, release_pulse, btn_held, hold_pulse;
  logic [7:0] press_count;
  int checks = 0;
  int errors = 0;
  button_debouncer #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .CNT_W(8)) dut (
    .i_clk(clk), .i_reset(reset), .i_btn_raw(btn_raw), .i_count_clr(count_clr),
    .o_btn_level(btn_level), .o_press_pulse(press_pulse), .o_release_pulse(release_pulse),
    .o_btn_held(btn_held), .o_hold_pulse(hold_pulse), .o_press_count(press_count)
  );
  always #5 clk = ~clk;
  logic       m_s1, m_s2, m_prev, m_level, m_press, m_rel, m_held, m_hold_p, m_in;
  logic [D:0] m_hist;
  int         m_hcnt;
  logic [7:0] m_cnt;
  // An edge is accepted once the last D+1 samples seen behind the synchronizer all oppose the level;
  // hold time counts consecutive pressed samples after acceptance.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      {m_s1, m_s2, m_prev, m_level, m_press, m_rel, m_held, m_hold_p} = '0;
      m_hist = '0;
      m_hcnt = 0;
      m_cnt  = '0;
    end else begin
      m_in = m_s2;
      m_s2 = m_s1;
      m_s1 = btn_raw;
      {m_press, m_rel, m_hold_p} = '0;
      m_hist = {m_hist[D-1:0], m_in};
      if (!m_level && &m_hist) begin
        m_level = 1'b1;
        m_press = 1'b1;
        m_hcnt  = 0;
      end else if (m_level && ~|m_hist) begin
        m_level = 1'b0;
        m_rel   = 1'b1;
        m_held  = 1'b0;
      end else if (m_level && m_in && m_prev && !m_held) begin
        m_hcnt++;
        if (m_hcnt == H) begin
          m_held   = 1'b1;
          m_hold_p = 1'b1;
        end
      end
      m_prev = m_in;
      m_cnt  = count_clr ? {7'd0, m_press} : m_cnt + {7'd0, m_press};
    end
  end
  task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask
  always @(negedge clk) begin
    chk("level", {7'd0, btn_level}, {7'd0, m_level});
    chk("press_pulse", {7'd0, press_pulse}, {7'd0, m_press});
    chk("release_pulse", {7'd0, release_pulse}, {7'd0, m_rel});
    chk("held", {7'd0, btn_held}, {7'd0, m_held});
    chk("hold_pulse", {7'd0, hold_pulse}, {7'd0, m_hold_p});
    chk("press_count", press_count, m_cnt);
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press_release();
    btn_raw = 1'b1;
    tick(8);
    btn_raw = 1'b0;
    tick(8);
  endtask
  initial begin
    tick(2);
    chk("rst_level", {7'd0, btn_level}, 8'd0);
    chk("rst_count", press_count, 8'd0);
    reset = 1'b0;
    tick(2);
    foreach (m_hist[i]) begin
      btn_raw = 1'b1;
      tick(2);
      btn_raw = 1'b0;
      tick(2);
      if (i == 2) break;
    end
    tick(12);
    chk("bounce_level", {7'd0, btn_level}, 8'd0);
    chk("bounce_count", press_count, 8'd0);
    btn_raw = 1'b1;
    tick(6);
    chk("clean_pre_pulse", {7'd0, press_pulse}, 8'd0);
    tick(1);
    chk("clean_pulse", {7'd0, press_pulse}, 8'd1);
    chk("clean_level", {7'd0, btn_level}, 8'd1);
    chk("clean_count", press_count, 8'd1);
    tick(9);
    chk("hold_pre", {7'd0, hold_pulse}, 8'd0);
    tick(1);
    chk("hold_pulse", {7'd0, hold_pulse}, 8'd1);
    chk("hold_held", {7'd0, btn_held}, 8'd1);
    tick(20);
    chk("hold_still", {7'd0, btn_held}, 8'd1);
    btn_raw = 1'b0;
    tick(2);
    btn_raw = 1'b1;
    tick(3);
    btn_raw = 1'b0;
    tick(6);
    chk("rel_pre_level", {7'd0, btn_level}, 8'd1);
    chk("rel_pre_held", {7'd0, btn_held}, 8'd1);
    tick(1);
    chk("rel_pulse", {7'd0, release_pulse}, 8'd1);
    chk("rel_level", {7'd0, btn_level}, 8'd0);
    chk("rel_held", {7'd0, btn_held}, 8'd0);
    tick(4);
    for (int k = 0; k < 255; k++) press_release();
    chk("wrap_count", press_count, 8'd0);
    btn_raw = 1'b1;
    tick(6);
    count_clr = 1'b1;
    tick(1);
    count_clr = 1'b0;
    chk("clr_press_count", press_count, 8'd1);
    btn_raw = 1'b0;
    tick(8);
    count_clr = 1'b1;
    tick(1);
    count_clr = 1'b0;
    chk("clr_only_count", press_count, 8'd0);
    btn_raw = 1'b1;
    tick(18);
    chk("mid_held", {7'd0, btn_held}, 8'd1);
    reset = 1'b1;
    #1;
    chk("async_level", {7'd0, btn_level}, 8'd0);
    chk("async_held", {7'd0, btn_held}, 8'd0);
    chk("async_rel", {7'd0, release_pulse}, 8'd0);
    tick(1);
    reset = 1'b0;
    tick(6);
    chk("post_rst_pre", {7'd0, press_pulse}, 8'd0);
    tick(1);
    chk("post_rst_pulse", {7'd0, press_pulse}, 8'd1);
    chk("post_rst_count", press_count, 8'd1);
    btn_raw = 1'b0;
    tick(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
Conditions the raw mechanical push-button from the board pin into the clean signals the game FSM consumes: a debounced level, a one-cycle press pulse on each accepted press, a one-cycle release pulse, and a long-press (hold) indication. It drives the game block's debounced button input and sits directly behind the pin in the top level. It also keeps a wrapping press counter for debug display.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, consecutive stable synchronized samples required to accept an edge (10 ms at 100 MHz); legal range >= 1
HOLD_CYCLES, 100_000_000, cycles in the pressed state before a hold is flagged (1 s at 100 MHz); legal range >= 1
CNT_W, 27, width of the internal counters; must hold max(DEBOUNCE_CYCLES, HOLD_CYCLES) - 1

Ports:
clk  input  1  system clock; single clock domain
reset  input  1  asynchronous, active-high reset
btn_raw  input  1  raw asynchronous button pin; 1 = pressed
count_clr  input  1  synchronous clear of press_count
btn_level  output  1  debounced button level
press_pulse  output  1  one-cycle pulse on each accepted press
release_pulse  output  1  one-cycle pulse on each accepted release
btn_held  output  1  high from the hold detection until the accepted release
hold_pulse  output  1  one-cycle pulse when btn_held rises
press_count  output  8  number of accepted presses, modulo 256

Behaviour:
- Reset: the design has one clock, and reset is asynchronous and active-high.
  - On reset, the synchronizer flops, the counters, all outputs and press_count go to 0.
  - The FSM returns to UP.
  - Asserting reset mid-press produces no release_pulse.
- Synchronizer: two flops, sync1 then sync2. The FSM reads only sync2.
- FSM states and transitions. All outputs are registered.
  - UP:
    - sync2=1 -> go to WAIT_DOWN, deb_cnt=0.
  - WAIT_DOWN:
    - sync2=0 -> back to UP (bounce); no outputs change.
    - sync2=1 and deb_cnt==DEBOUNCE_CYCLES-1 -> go to DOWN. Set btn_level=1, press_pulse=1 and hold_cnt=0.
    - Otherwise deb_cnt+1.
  - DOWN:
    - sync2=0 -> go to WAIT_UP, deb_cnt=0.
    - Else, if btn_held=0: when hold_cnt==HOLD_CYCLES-1, set btn_held=1 and hold_pulse=1; otherwise hold_cnt+1.
    - hold_cnt freezes once btn_held=1.
  - WAIT_UP:
    - sync2=1 -> back to DOWN (bounce). No pulse is emitted, and hold_cnt/btn_held are kept.
    - sync2=0 and deb_cnt==DEBOUNCE_CYCLES-1 -> go to UP. Set btn_level=0, release_pulse=1 and btn_held=0.
    - Otherwise deb_cnt+1. hold_cnt does not advance in WAIT_UP.
- Latency:
  - Number the first clk edge that samples btn_raw=1 as edge 1. press_pulse is registered high at edge DEBOUNCE_CYCLES+3, provided btn_raw stays high throughout.
  - The release path has the same latency.
- Pulses:
  - press_pulse, release_pulse and hold_pulse are each exactly one cycle wide.
  - press_pulse and release_pulse are never high in the same cycle.
  - hold_pulse fires at most once per press.
- press_count:
  - Increments by 1 on each press_pulse and wraps 255 -> 0.
  - count_clr=1 loads 0.
  - If count_clr and a press acceptance occur in the same cycle, press_count = 1.
- Glitches: any glitch shorter than DEBOUNCE_CYCLES synchronized samples never changes btn_level.
- Bounce stretching: a bounce during WAIT_DOWN or WAIT_UP restarts the qualification. Continuous bouncing therefore holds the outputs indefinitely.
- DEBOUNCE_CYCLES=1: an edge is accepted on the first FSM cycle in the WAIT state.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=10):
- Clean press: btn_raw 0 -> 1 held, first sampling edge = 1 -> press_pulse high only after edge 7; btn_level=1 from edge 7; press_count=1.
- Bounce: btn_raw toggles 1,0,1,0 with 2-cycle periods, then stays 0 -> no press_pulse, btn_level stays 0, press_count=0.
- Hold: press held 30 cycles after acceptance -> hold_pulse exactly once, 10 edges after press_pulse. btn_held stays 1 until release_pulse, then 0. No second hold_pulse.
- Release bounce: while DOWN, btn_raw drops 2 cycles, returns 1, then drops for good -> no pulses on the short drop; a single release_pulse 7 edges after the final drop is sampled.
- Wrap and clear: 256 clean presses -> press_count=0. Next press coincident with count_clr -> press_count=1. count_clr alone -> 0.
- Reset mid-press: assert reset while DOWN with btn_held=1 -> all outputs 0 immediately, no release_pulse. With btn_raw still high after reset deasserts, a fresh press_pulse is registered at edge 7.
